// File: rtl/signmag_seq_mul.sv
// Sequential sign-magnitude multiplier: one multiplier bit per cycle by shift-add,
// then fixed-point scaling to a two's-complement result with optional saturation.
module signmag_seq_mul #(
    parameter int WIDTH = 7,
    parameter int FRAC  = 0,
    parameter int OUT_W = 32,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    input  logic             sign_a,
    input  logic             sign_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             sign,
    output logic             overflow
);

    localparam int PW    = 2 * WIDTH;
    localparam int CW    = ((PW > OUT_W) ? PW : OUT_W) + 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    MAX_POS  = (CW'(1) << (OUT_W - 1)) - CW'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] result_q, result_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;

    logic [PW-1:0]    p_next;
    logic [PW-1:0]    q;
    logic [CW-1:0]    qx;
    logic             fin_ovf;
    logic             fin_sign;
    logic [OUT_W-1:0] fin_mag;
    logic [OUT_W-1:0] fin_result;
    logic             last_step;

    // Handshake: operands transfer on a rising edge where in_valid && in_ready;
    // the result transfers on a rising edge where out_valid && out_ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign sign      = sign_q;
    assign overflow  = ovf_q;

    // Datapath: a_q is pre-shifted by the current bit position, b_q is consumed LSB first.
    always_comb begin
        p_next     = p_q + (b_q[0] ? a_q : '0);
        q          = p_next >> FRAC;
        qx         = '0;
        qx[PW-1:0] = q;
        fin_ovf    = (qx > MAX_POS);
        fin_sign   = neg_q && (q != '0);
        fin_mag    = (fin_ovf && (SAT != 0)) ? MAX_POS[OUT_W-1:0] : qx[OUT_W-1:0];
        fin_result = fin_sign ? (~fin_mag + OUT_W'(1)) : fin_mag;
        // A zero operand is seen on the first BUSY cycle, so it finishes one edge after accept.
        last_step  = (cnt_q == LAST_CNT) ||
                     ((cnt_q == '0) && ((a_q == '0) || (b_q == '0)));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = {{WIDTH{1'b0}}, mag_a};
                    b_d     = mag_b;
                    neg_d   = sign_a ^ sign_b;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                p_d   = p_next;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    result_d = fin_result;
                    sign_d   = fin_sign;
                    ovf_d    = fin_ovf;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_signmag_seq_mul.sv
// Bench for signmag_seq_mul: four configurations driven by directed vectors,
// expectations queued at issue time and checked by a monitor on output handshakes.
module tb_signmag_seq_mul;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]  iv, ordy, sa, sb;
    logic [15:0] ma[4];
    logic [15:0] mb[4];
    logic [3:0]  ir, ovld, sg, ovf;
    logic [31:0] r0, r3;
    logic [15:0] r1, r2;
    logic [31:0] res[4];

    int checks   = 0;
    int failures = 0;
    logic [35:0] exp_q[$];
    logic [35:0] mon_e;

    always_comb begin
        res[0] = r0;
        res[1] = {16'h0, r1};
        res[2] = {16'h0, r2};
        res[3] = r3;
    end

    signmag_seq_mul #(.WIDTH(7), .FRAC(0), .OUT_W(32), .SAT(1)) dut0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .mag_a(ma[0][6:0]), .mag_b(mb[0][6:0]), .sign_a(sa[0]), .sign_b(sb[0]),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .result(r0), .sign(sg[0]), .overflow(ovf[0]));

    signmag_seq_mul #(.WIDTH(16), .FRAC(0), .OUT_W(16), .SAT(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .mag_a(ma[1]), .mag_b(mb[1]), .sign_a(sa[1]), .sign_b(sb[1]),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .result(r1), .sign(sg[1]), .overflow(ovf[1]));

    signmag_seq_mul #(.WIDTH(16), .FRAC(0), .OUT_W(16), .SAT(0)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .mag_a(ma[2]), .mag_b(mb[2]), .sign_a(sa[2]), .sign_b(sb[2]),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .result(r2), .sign(sg[2]), .overflow(ovf[2]));

    signmag_seq_mul #(.WIDTH(8), .FRAC(4), .OUT_W(32), .SAT(1)) dut3 (
        .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(ir[3]),
        .mag_a(ma[3][7:0]), .mag_b(mb[3][7:0]), .sign_a(sa[3]), .sign_b(sb[3]),
        .out_valid(ovld[3]), .out_ready(ordy[3]), .result(r3), .sign(sg[3]), .overflow(ovf[3]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 4; d++) begin
                if (ovld[d] && ordy[d]) begin
                    if (exp_q.size() == 0) begin
                        check("mon_unexpected_output", 64'(d), 64'hDEAD);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("mon_dut_id", 64'(d), 64'(mon_e[35:34]));
                        check("mon_result", 64'(res[d]), 64'(mon_e[33:2]));
                        check("mon_sign", 64'(sg[d]), 64'(mon_e[1]));
                        check("mon_overflow", 64'(ovf[d]), 64'(mon_e[0]));
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int d, output logic ok);
        int n;
        n = 0;
        while (!ir[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = ir[d];
        if (!ok) check("in_ready_timeout", 64'(ir[d]), 64'd1);
    endtask

    task automatic run_op(input int d, input logic [15:0] a, input logic s_a,
                          input logic [15:0] b, input logic s_b, input logic [31:0] e_res,
                          input logic e_sg, input logic e_ov, input int e_lat, input int hold);
        int n;
        logic ok, leak;
        logic [31:0] r_hold;
        logic s_hold, o_hold;
        wait_ready(d, ok);
        if (!ok) return;
        ma[d] = a; sa[d] = s_a; mb[d] = b; sb[d] = s_b;
        iv[d] = 1'b1;
        ordy[d] = (hold == 0);
        exp_q.push_back({2'(d), e_res, e_sg, e_ov});
        @(posedge clk); #1;
        iv[d] = 1'b0;
        // Operand pins must not matter after the accept edge.
        ma[d] = 16'($urandom); mb[d] = 16'($urandom);
        sa[d] = 1'($urandom); sb[d] = 1'($urandom);
        leak = ir[d];
        n = 0;
        while (!ovld[d] && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ir[d]) leak = 1'b1;
        end
        check("latency", 64'(n), 64'(e_lat));
        if (hold > 0) begin
            r_hold = res[d]; s_hold = sg[d]; o_hold = ovf[d];
            repeat (hold) begin
                @(posedge clk); #1;
                check("hold_stable", {ovld[d], ir[d], sg[d], ovf[d], res[d]},
                      {1'b1, 1'b0, s_hold, o_hold, r_hold});
            end
            ordy[d] = 1'b1;
        end
        @(posedge clk); #1;
        check("release_to_idle", {ovld[d], ir[d]}, 2'b01);
        check("result_retained", 64'(res[d]), 64'(e_res));
        check("in_ready_low_while_busy", 64'(leak), 64'd0);
    endtask

    task automatic reset_mid_busy();
        logic ok;
        wait_ready(0, ok);
        if (!ok) return;
        ma[0] = 16'd5; sa[0] = 1'b0; mb[0] = 16'd3; sb[0] = 1'b1;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy_counter", 64'(dut0.cnt_q), 64'd3);
        reset = 1'b1;
        #1;
        check("abort_outputs", {ir[0], ovld[0], sg[0], ovf[0], res[0]}, {4'b1000, 32'h0});
        check("abort_state", 64'(dut0.state_q), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        iv = '0; ordy = '1; sa = '0; sb = '0;
        for (int d = 0; d < 4; d++) begin
            ma[d] = '0; mb[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {ir[0], ovld[0], sg[0], ovf[0], res[0]}, {4'b1000, 32'h0});
        check("reset_fsm_state", 64'(dut0.state_q), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Default configuration
        run_op(0, 16'd5,   1'b0, 16'd3,   1'b1, 32'hFFFF_FFF1, 1'b1, 1'b0, 7, 0);
        run_op(0, 16'd127, 1'b0, 16'd127, 1'b0, 32'h0000_3F01, 1'b0, 1'b0, 7, 0);
        run_op(0, 16'd127, 1'b1, 16'd127, 1'b1, 32'h0000_3F01, 1'b0, 1'b0, 7, 0);
        run_op(0, 16'd0,   1'b1, 16'd9,   1'b0, 32'h0,         1'b0, 1'b0, 1, 0);
        run_op(0, 16'd9,   1'b0, 16'd0,   1'b1, 32'h0,         1'b0, 1'b0, 1, 0);
        run_op(0, 16'd7,   1'b0, 16'd9,   1'b0, 32'h0000_003F, 1'b0, 1'b0, 7, 0);

        // 16-bit result, saturating and wrapping
        run_op(1, 16'd300, 1'b0, 16'd300, 1'b0, 32'h0000_7FFF, 1'b0, 1'b1, 16, 0);
        run_op(1, 16'd300, 1'b1, 16'd300, 1'b0, 32'h0000_8001, 1'b1, 1'b1, 16, 0);
        run_op(1, 16'd217, 1'b1, 16'd151, 1'b0, 32'h0000_8001, 1'b1, 1'b0, 16, 0);
        run_op(1, 16'd128, 1'b0, 16'd256, 1'b0, 32'h0000_7FFF, 1'b0, 1'b1, 16, 0);
        run_op(1, 16'd181, 1'b0, 16'd181, 1'b0, 32'h0000_7FF9, 1'b0, 1'b0, 16, 0);
        run_op(2, 16'd300, 1'b0, 16'd300, 1'b0, 32'h0000_5F90, 1'b0, 1'b1, 16, 0);
        run_op(2, 16'd300, 1'b1, 16'd300, 1'b0, 32'h0000_A070, 1'b1, 1'b1, 16, 0);

        // Q4 fixed point with back-pressure
        run_op(3, 16'h18, 1'b0, 16'h28, 1'b0, 32'h0000_003C, 1'b0, 1'b0, 8, 5);
        run_op(3, 16'h18, 1'b1, 16'h28, 1'b0, 32'hFFFF_FFC4, 1'b1, 1'b0, 8, 0);
        run_op(3, 16'h01, 1'b1, 16'h0F, 1'b0, 32'h0,         1'b0, 1'b0, 8, 0);

        // Abort in mid-BUSY, then a clean operation
        reset_mid_busy();
        run_op(0, 16'd6, 1'b1, 16'd7, 1'b0, 32'hFFFF_FFD6, 1'b1, 1'b0, 7, 0);

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
